// File: rtl/dds_lfsr_pkg.sv
// Shared types and constants for the DDS noise/dither LFSR seed sequencer.
// Provides the lane count, seed width, controller state enum, the power-up seed
// table and the substitute used for zero seeds, which would lock an LFSR up.
package dds_lfsr_pkg;

    localparam int unsigned SEED_W = 24;
    localparam int unsigned NLANE  = 4;
    localparam int unsigned LANE_W = 2;

    typedef logic [SEED_W-1:0] seed_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    localparam seed_t DEFAULT_SEED [NLANE] = '{
        24'h000001, 24'h5A5A5A, 24'hC3C3C3, 24'h0F0F0F
    };

    localparam seed_t ZERO_SUB_SEED = 24'h000001;

    // Zero would freeze an LFSR forever, so it is replaced on the way in.
    function automatic seed_t sanitize_seed(input seed_t s);
        return (s == '0) ? ZERO_SUB_SEED : s;
    endfunction

endpackage

// File: rtl/lfsr_seed_sequencer_if.sv
// Seed-write port of the LFSR seed sequencer.
//   cfg_valid : request, held by the requester until accepted
//   cfg_ready : accept, driven by the sequencer
//   cfg_lane  : target lane
//   cfg_seed  : seed value
// A write completes on any clock edge where cfg_valid && cfg_ready.
interface lfsr_seed_sequencer_if;
    import dds_lfsr_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [LANE_W-1:0] cfg_lane;
    seed_t             cfg_seed;

    modport master (
        output cfg_valid,
        output cfg_lane,
        output cfg_seed,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_lane,
        input  cfg_seed,
        output cfg_ready
    );

endinterface

// File: rtl/lfsr_reseed_timer.sv
// Reseed interval timer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to zero (wins over en)
//   en       : advance the count by one
//   expire   : count has reached RESEED_CYC-1; constant 0 when RESEED_CYC == 0
module lfsr_reseed_timer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RESEED_CYC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RESEED_CYC - 1);
    localparam bit               ENABLED = (RESEED_CYC != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/lfsr_seed_sequencer.sv
// Seed sequencer for the four DDS noise/dither LFSR lanes.
// Holds a per-lane seed shadow written through the cfg port, and on start (or
// periodic auto-reseed) walks the lanes out of reset one per cycle while driving
// each lane's seed on the shared initval bus. Every output is a flop.
//   clk, rst     : clock, synchronous active-high reset
//   start, stop  : begin a reseed sequence / hold all lanes in reset (stop wins)
//   cfg          : seed-write port (slave side)
//   lane_rst     : per-lane LFSR reset, lane_initval : shared seed bus
//   busy/running : in LOAD / in RUN; done : LOAD->RUN pulse
//   zero_sub     : pulse the cycle after a zero seed was accepted and replaced
module lfsr_seed_sequencer
    import dds_lfsr_pkg::*;
#(
    parameter int unsigned RESEED_CYC = 0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    lfsr_seed_sequencer_if.slave  cfg,
    output logic [NLANE-1:0]      lane_rst,
    output seed_t                 lane_initval,
    output logic                  busy,
    output logic                  running,
    output logic                  done,
    output logic                  zero_sub
);

    state_e            state_q, state_d;
    logic [LANE_W-1:0] k_q, k_d;
    seed_t             seed_q [NLANE];
    seed_t             seed_d [NLANE];
    logic [NLANE-1:0]  lane_rst_q, lane_rst_d;
    seed_t             lane_initval_q, lane_initval_d;
    logic              busy_q, busy_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              zero_sub_q, zero_sub_d;
    logic              cfg_ready_q, cfg_ready_d;

    logic accept;
    logic timer_clear;
    logic timer_en;
    logic timer_expire;

    lfsr_reseed_timer #(
        .CNT_W      (CNT_W),
        .RESEED_CYC (RESEED_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        accept     = cfg.cfg_valid && cfg_ready_q;
        seed_d     = seed_q;
        zero_sub_d = 1'b0;
        if (accept) begin
            seed_d[cfg.cfg_lane] = sanitize_seed(cfg.cfg_seed);
            zero_sub_d           = (cfg.cfg_seed == '0);
        end

        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    k_d     = '0;
                end
            end
            StLoad: begin
                // start is deliberately ignored here; k wraps to 0 on exit.
                k_d = k_q + 1'b1;
                if (k_q == LANE_W'(NLANE - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (start || timer_expire) begin
                    state_d = StLoad;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                k_d     = '0;
            end
        endcase
        if (stop) begin
            state_d = StIdle;
            k_d     = '0;
        end

        timer_en    = (state_q == StRun);
        timer_clear = (state_d != StRun);

        // Outputs are decoded from next state and next seeds so that a seed
        // written alongside start is already visible in LOAD cycle 0.
        lane_rst_d     = '1;
        lane_initval_d = seed_d[0];
        unique case (state_d)
            StLoad: begin
                lane_rst_d     = {NLANE{1'b1}} << k_d;
                lane_initval_d = seed_d[k_d];
            end
            StRun: begin
                lane_rst_d     = '0;
                lane_initval_d = lane_initval_q;
            end
            default: begin
                lane_rst_d     = '1;
                lane_initval_d = seed_d[0];
            end
        endcase

        busy_d      = (state_d == StLoad);
        running_d   = (state_d == StRun);
        done_d      = (state_q == StLoad) && (state_d == StRun);
        cfg_ready_d = (state_d != StLoad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            seed_q         <= DEFAULT_SEED;
            lane_rst_q     <= '1;
            lane_initval_q <= DEFAULT_SEED[0];
            busy_q         <= 1'b0;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
            zero_sub_q     <= 1'b0;
            cfg_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            seed_q         <= seed_d;
            lane_rst_q     <= lane_rst_d;
            lane_initval_q <= lane_initval_d;
            busy_q         <= busy_d;
            running_q      <= running_d;
            done_q         <= done_d;
            zero_sub_q     <= zero_sub_d;
            cfg_ready_q    <= cfg_ready_d;
        end
    end

    assign lane_rst      = lane_rst_q;
    assign lane_initval  = lane_initval_q;
    assign busy          = busy_q;
    assign running       = running_q;
    assign done          = done_q;
    assign zero_sub      = zero_sub_q;
    assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_lfsr_seed_sequencer.sv
// Self-checking bench for lfsr_seed_sequencer: one instance without auto reseed,
// one with a 16-cycle reseed interval. LOAD-cycle expectations are queued when
// start is driven and popped whenever the first instance reports busy.
module tb_lfsr_seed_sequencer;

    typedef struct packed {
        logic [3:0]  rst_v;
        logic [23:0] iv;
    } load_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, stop0 = 1'b0;
    logic start1 = 1'b0, stop1 = 1'b0;

    logic [3:0]  lane_rst0, lane_rst1;
    logic [23:0] lane_initval0, lane_initval1;
    logic busy0, running0, done0, zero_sub0;
    logic busy1, running1, done1, zero_sub1;

    int n_checks = 0;
    int n_errors = 0;
    load_exp_t sb_q[$];

    lfsr_seed_sequencer_if if0 ();
    lfsr_seed_sequencer_if if1 ();

    always #5 clk = ~clk;

    lfsr_seed_sequencer #(.RESEED_CYC(0), .CNT_W(32)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .start        (start0),
        .stop         (stop0),
        .cfg          (if0),
        .lane_rst     (lane_rst0),
        .lane_initval (lane_initval0),
        .busy         (busy0),
        .running      (running0),
        .done         (done0),
        .zero_sub     (zero_sub0)
    );

    lfsr_seed_sequencer #(.RESEED_CYC(16), .CNT_W(32)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start1),
        .stop         (stop1),
        .cfg          (if1),
        .lane_rst     (lane_rst1),
        .lane_initval (lane_initval1),
        .busy         (busy1),
        .running      (running1),
        .done         (done1),
        .zero_sub     (zero_sub1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_one(input logic [3:0] r, input logic [23:0] iv);
        load_exp_t e;
        e.rst_v = r;
        e.iv    = iv;
        sb_q.push_back(e);
    endtask

    task automatic push_load(input logic [23:0] s0, input logic [23:0] s1,
                             input logic [23:0] s2, input logic [23:0] s3);
        push_one(4'b1111, s0);
        push_one(4'b1110, s1);
        push_one(4'b1100, s2);
        push_one(4'b1000, s3);
    endtask

    // Advance one cycle, sample 1 ns after the edge and score any LOAD cycle.
    task automatic tick();
        load_exp_t e;
        @(posedge clk);
        #1;
        if (busy0 === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("load_rst", {28'd0, lane_rst0}, {28'd0, e.rst_v});
                check("load_iv", {8'd0, lane_initval0}, {8'd0, e.iv});
                check("load_ready", {31'd0, if0.cfg_ready}, 32'd0);
            end
        end
    endtask

    task automatic do_start(input logic wr, input logic [1:0] ln, input logic [23:0] sd,
                            input logic [23:0] s0, input logic [23:0] s1,
                            input logic [23:0] s2, input logic [23:0] s3);
        push_load(s0, s1, s2, s3);
        if (wr) begin
            if0.cfg_valid = 1'b1;
            if0.cfg_lane  = ln;
            if0.cfg_seed  = sd;
        end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        if0.cfg_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("run_running", {31'd0, running0}, 32'd1);
        check("run_done", {31'd0, done0}, 32'd1);
        check("run_lane_rst", {28'd0, lane_rst0}, 32'd0);
        check("run_busy", {31'd0, busy0}, 32'd0);
        check("run_ready", {31'd0, if0.cfg_ready}, 32'd1);
        check("run_iv_hold", {8'd0, lane_initval0}, {8'd0, s3});
        tick();
        check("done_once", {31'd0, done0}, 32'd0);
        check("still_run", {31'd0, running0}, 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [23:0] s0);
        check({tag, "_rst"}, {28'd0, lane_rst0}, 32'hF);
        check({tag, "_iv"}, {8'd0, lane_initval0}, {8'd0, s0});
        check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_running"}, {31'd0, running0}, 32'd0);
        check({tag, "_done"}, {31'd0, done0}, 32'd0);
        check({tag, "_ready"}, {31'd0, if0.cfg_ready}, 32'd1);
    endtask

    initial begin
        int n;
        if0.cfg_valid = 1'b0;
        if0.cfg_lane  = 2'd0;
        if0.cfg_seed  = 24'd0;
        if1.cfg_valid = 1'b0;
        if1.cfg_lane  = 2'd0;
        if1.cfg_seed  = 24'd0;

        // Reset, then idle.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_idle("reset", 24'h000001);
        check("reset_zero_sub", {31'd0, zero_sub0}, 32'd0);

        // Default sequence.
        do_start(1'b0, 2'd0, 24'd0, 24'h000001, 24'h5A5A5A, 24'hC3C3C3, 24'h0F0F0F);

        // Zero seed write to lane 2 in RUN.
        if0.cfg_valid = 1'b1;
        if0.cfg_lane  = 2'd2;
        if0.cfg_seed  = 24'h000000;
        tick();
        if0.cfg_valid = 1'b0;
        check("zero_sub_pulse", {31'd0, zero_sub0}, 32'd1);
        check("write_no_reseed", {31'd0, running0}, 32'd1);
        tick();
        check("zero_sub_once", {31'd0, zero_sub0}, 32'd0);
        do_start(1'b0, 2'd0, 24'd0, 24'h000001, 24'h5A5A5A, 24'h000001, 24'h0F0F0F);

        // Lane 1 write coincident with start in RUN.
        do_start(1'b1, 2'd1, 24'hABCDEF, 24'h000001, 24'hABCDEF, 24'h000001, 24'h0F0F0F);

        // start and stop together in RUN: stop wins.
        start0 = 1'b1;
        stop0  = 1'b1;
        tick();
        start0 = 1'b0;
        stop0  = 1'b0;
        check_idle("startstop", 24'h000001);

        // stop during LOAD k=1.
        push_one(4'b1111, 24'h000001);
        push_one(4'b1110, 24'hABCDEF);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        check_idle("stop_load", 24'h000001);
        tick();
        check_idle("stop_after", 24'h000001);

        // rst mid-LOAD restores all reset values, including the seed shadows.
        push_one(4'b1111, 24'h000001);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_load", 24'h000001);
        check("rst_load_zero_sub", {31'd0, zero_sub0}, 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);
        do_start(1'b0, 2'd0, 24'd0, 24'h000001, 24'h5A5A5A, 24'hC3C3C3, 24'h0F0F0F);

        // Auto reseed on the second instance.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (running1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ar_enter_run", {31'd0, running1}, 32'd1);
        n = 0;
        while (busy1 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("ar_period1", n, 32'd16);
        check("ar_k0_ready", {31'd0, if1.cfg_ready}, 32'd0);
        // Zero write held through LOAD: only accepted once RUN is reached.
        if1.cfg_valid = 1'b1;
        if1.cfg_lane  = 2'd2;
        if1.cfg_seed  = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_load_ready", {31'd0, if1.cfg_ready}, 32'd0);
            check("ar_load_nosub", {31'd0, zero_sub1}, 32'd0);
        end
        tick();
        check("ar_run", {31'd0, running1}, 32'd1);
        check("ar_done", {31'd0, done1}, 32'd1);
        check("ar_run_ready", {31'd0, if1.cfg_ready}, 32'd1);
        check("ar_run_nosub", {31'd0, zero_sub1}, 32'd0);
        tick();
        if1.cfg_valid = 1'b0;
        check("ar_accept_sub", {31'd0, zero_sub1}, 32'd1);
        n = 1;
        while (busy1 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("ar_period2", n, 32'd16);
        tick();
        tick();
        check("ar_k2_iv", {8'd0, lane_initval1}, 32'h000001);
        check("ar_k2_rst", {28'd0, lane_rst1}, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_seed_sequencer.md
Name: lfsr_seed_sequencer

Overview:
- Controller for the four 24-bit noise/dither LFSR lanes in the DDS.
- Each lane loads its initval while its rst is high, and shifts every clock otherwise.
- This block holds a per-lane seed shadow, writable through a valid/ready port.
- It sequences lane reseeding over one shared initval bus, guarantees no lane is ever seeded with zero (LFSR lock-up), and optionally reseeds periodically.

Parameters:
- SEED_W, 24, LFSR state/seed width.
- NLANE, 4, number of LFSR lanes; fixed at 4 in this revision.
- RESEED_CYC, 0, cycles in RUN before an automatic reseed; 0 disables auto reseed.
- CNT_W, 32, width of the reseed timer; RESEED_CYC must be less than 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  pulse: begin a reseed sequence
- stop  in  1  pulse: halt all lanes (hold them in reset)
- cfg_valid  in  1  seed write request
- cfg_ready  out  1  seed write accept
- cfg_lane  in  2  target lane of the seed write
- cfg_seed  in  SEED_W  seed value
- lane_rst  out  NLANE  per-lane reset to the LFSR lanes
- lane_initval  out  SEED_W  shared seed bus to all lanes
- busy  out  1  high in LOAD
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on the LOAD->RUN transition
- zero_sub  out  1  one-cycle pulse, the cycle after a zero seed write is accepted

Behaviour:
- States: IDLE, LOAD, RUN. A 2-bit index k counts within LOAD.
- All outputs come straight from registers; there is no combinational path from inputs to outputs.
- Reset values:
  - state=IDLE, k=0, timer=0.
  - lane_rst=4'b1111, lane_initval=DEFAULT_SEED[0].
  - busy=0, running=0, done=0, zero_sub=0, cfg_ready=1.
  - Seed shadows: DEFAULT_SEED = {24'h000001, 24'h5A5A5A, 24'hC3C3C3, 24'h0F0F0F}, lanes 0..3.
- IDLE:
  - lane_rst=1111, lane_initval=seed_sh[0].
  - start -> LOAD with k=0.
- LOAD (4 cycles, k=0..3):
  - lane_rst has bits k..3 set and bits below k clear; lane_initval=seed_sh[k].
  - Lane k is therefore last loaded in LOAD cycle k and runs from the next cycle.
  - Fixed inter-lane skew: lane j starts 3-j cycles before the LOAD->RUN transition.
  - After k=3 -> RUN, with done=1 for exactly one cycle.
  - start is ignored during LOAD.
- RUN:
  - lane_rst=0000; lane_initval holds seed_sh[3].
  - The timer increments every cycle.
  - If RESEED_CYC!=0 and timer==RESEED_CYC-1 -> LOAD with k=0, timer cleared.
  - start -> LOAD with k=0, timer cleared.
- stop in any state -> IDLE next cycle, timer cleared. stop has priority over start and over auto reseed.
- A LOAD aborted by stop leaves every lane in reset (IDLE outputs).
- Seed writes:
  - cfg_ready=1 in IDLE and RUN, 0 in LOAD (held low for all of LOAD).
  - On cfg_valid&&cfg_ready: seed_sh[cfg_lane] <= (cfg_seed==0) ? 24'h000001 : cfg_seed.
  - A zero seed also pulses zero_sub the following cycle.
  - A write alone never reseeds; the new seed takes effect at the next LOAD.
  - A write accepted in the same cycle as a start (or auto-reseed trigger) in RUN is committed before LOAD cycle 0, so the new value is used.
  - cfg_valid while cfg_ready=0 is not accepted; the requester holds the request.
- Invariant: lane_initval is never zero while any lane_rst bit is set.

Decomposition:
- Package dds_lfsr_pkg: SEED_W, NLANE, state enum (IDLE/LOAD/RUN), DEFAULT_SEED array, ZERO_SUB_SEED=24'h000001.
- Sub-module lfsr_reseed_timer (CNT_W counter):
  - inputs clear, en; output expire.
  - expire is tied off when RESEED_CYC=0.

Test Plan:
- Reset then idle 10 cycles -> lane_rst=1111, lane_initval=24'h000001, cfg_ready=1, busy=0, running=0.
- start with defaults -> over 4 cycles lane_rst=1111/1110/1100/1000 with lane_initval=000001/5A5A5A/C3C3C3/0F0F0F; next cycle running=1, done pulses, lane_rst=0000.
- In RUN, write lane2 seed=24'h000000 -> zero_sub pulses; a following start drives 24'h000001 in LOAD cycle 2.
- RESEED_CYC=16 -> LOAD entered 16 cycles after each RUN entry, repeating periodically; a cfg_valid held through LOAD is accepted only on return to RUN.
- start and stop in the same cycle during RUN -> IDLE, lane_rst=1111. stop during LOAD k=1 -> IDLE next cycle, busy=0, no done pulse.
- Write lane1=24'hABCDEF in the same cycle as start in RUN -> LOAD cycle 1 drives 24'hABCDEF; rst asserted mid-LOAD -> all reset values the next cycle.
